// File: rtl/ysyx_22050612_ifu.sv
// Single-issue instruction fetch unit: owns the PC, fetches one doubleword at a time and
// hands the selected 32-bit word to decode. Optional ebreak halt: define IFU_EBREAK_HALT_EN.
module ysyx_22050612_ifu #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            halted
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold
`ifdef IFU_EBREAK_HALT_EN
    ,
    StHalt
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_err_q, inst_err_d;

  logic misaligned;
  logic req_fire;

  assign misaligned = (pc_q[1:0] != 2'b00);
  // A misaligned PC never reaches the bus; the fault is synthesised locally.
  assign imem_req_valid = (state_q == StReq) && !misaligned;
  assign imem_req_addr  = (state_q == StReq) ? {pc_q[XLEN-1:3], 3'b000} : '0;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = (state_q == StHold);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_err   = inst_err_q;

`ifdef IFU_EBREAK_HALT_EN
  localparam logic [31:0] Ebreak = 32'h0010_0073;
  assign halted = (state_q == StHalt);
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_err_d = inst_err_q;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (redirect_valid) pc_d = redirect_pc;
      end

      StReq: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // An accepted request still has a response in flight that must be discarded.
          if (req_fire) begin
            state_d = StWait;
            drop_d  = 1'b1;
          end
        end else if (misaligned) begin
          state_d    = StHold;
          inst_d     = 32'h0;
          inst_pc_d  = pc_q;
          inst_err_d = 1'b1;
        end else if (req_fire) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_resp_valid) begin
            state_d = StReq;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            inst_d     = pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
            inst_pc_d  = pc_q;
            inst_err_d = imem_resp_err;
            state_d    = StHold;
          end
        end
      end

      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StReq;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = StReq;
`ifdef IFU_EBREAK_HALT_EN
          if (inst_q == Ebreak) state_d = StHalt;
`endif
        end
      end

`ifdef IFU_EBREAK_HALT_EN
      StHalt: state_d = StHalt;
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      inst_q     <= 32'h0;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_err_q <= inst_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Directed bench for ysyx_22050612_ifu: per-cycle vector table plus hand-written sequences
// for hold stability, PC wrap, reset mid-transaction and the ebreak halt option.
module tb_ysyx_22050612_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_22050612_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [63:0] rdata;
    logic        rerr;
    logic        irdy;
    logic        redir;
    logic [63:0] rpc;
    logic        exp_rv;
    logic [63:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_inst;
    logic [63:0] exp_ipc;
    logic        exp_err;
  } vec_t;

  localparam logic [63:0] D = 64'h0010_0093_0000_0013;

  vec_t vecs[22];

  function automatic vec_t mk(logic rdy, logic rv, logic [63:0] rdata, logic rerr, logic irdy,
                              logic redir, logic [63:0] rpc, logic exp_rv, logic [63:0] exp_addr,
                              logic exp_iv, logic [31:0] exp_inst, logic [63:0] exp_ipc,
                              logic exp_err);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.rerr = rerr; v.irdy = irdy;
    v.redir = redir; v.rpc = rpc; v.exp_rv = exp_rv; v.exp_addr = exp_addr;
    v.exp_iv = exp_iv; v.exp_inst = exp_inst; v.exp_ipc = exp_ipc; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [63:0] rdata,
                       input logic rerr, input logic irdy, input logic redir,
                       input logic [63:0] rpc);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rdata;
    imem_resp_err   = rerr;
    inst_ready      = irdy;
    redirect_valid  = redir;
    redirect_pc     = rpc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0,                      1, 64'h8000_0000, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, D, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 0, 0,                      0, 0, 1, 32'h13, 64'h8000_0000, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0,                      1, 64'h8000_0000, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, D, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1, 0, 0,                      0, 0, 1, 32'h0010_0093,
                  64'h8000_0004, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,                      1, 64'h8000_0008, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 1, 64'h8000_0100,          1, 64'h8000_0008, 0, 0, 0, 0);
    vecs[9]  = mk(0, 1, D, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0,                      1, 64'h8000_0100, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 0);
    vecs[12] = mk(0, 1, 64'hAAAA_BBBB_1234_5678, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 1, 1, 64'h8000_0102,          0, 0, 1, 32'h1234_5678,
                  64'h8000_0100, 1);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 0,                      0, 64'h8000_0100, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 64'h8000_000C,          0, 0, 1, 32'h0, 64'h8000_0102, 1);
    vecs[16] = mk(1, 0, 0, 0, 0, 0, 0,                      1, 64'h8000_0008, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 1, 64'h8000_0200,          0, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, 1, D, 0, 0, 1, 64'h8000_0300,          0, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 0, 0, 0, 0, 0, 0,                      1, 64'h8000_0300, 0, 0, 0, 0);
    vecs[20] = mk(0, 1, D, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0,                      0, 0, 1, 32'h13, 64'h8000_0300, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 0);
    check("rst_req_addr", imem_req_addr, 0);
    check("rst_inst_valid", 64'(inst_valid), 0);
    check("rst_inst", 64'(inst), 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_err", 64'(inst_err), 0);
    check("rst_halted", 64'(halted), 0);
    rst_n = 1'b1;

    // Row i: outputs expected during cycle i, inputs applied during cycle i.
    for (int i = 0; i < 22; i++) begin
      check($sformatf("v%0d_req_valid", i), 64'(imem_req_valid), 64'(vecs[i].exp_rv));
      check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_inst_valid", i), 64'(inst_valid), 64'(vecs[i].exp_iv));
      if (vecs[i].exp_iv) begin
        check($sformatf("v%0d_inst", i), 64'(inst), 64'(vecs[i].exp_inst));
        check($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].exp_ipc);
        check($sformatf("v%0d_inst_err", i), 64'(inst_err), 64'(vecs[i].exp_err));
      end
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].rerr, vecs[i].irdy,
            vecs[i].redir, vecs[i].rpc);
      @(negedge clk);
    end

    // Decode stalls: held instruction stays put and no new fetch goes out.
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_valid", k), 64'(inst_valid), 1);
      check($sformatf("hold%0d_inst", k), 64'(inst), 64'h13);
      check($sformatf("hold%0d_pc", k), inst_pc, 64'h8000_0300);
      check($sformatf("hold%0d_req", k), 64'(imem_req_valid), 0);
      @(negedge clk);
    end

    // Redirect to the top of the address space and let the PC wrap.
    drive(0, 0, 0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    check("wrap_req_valid", 64'(imem_req_valid), 1);
    check("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 64'hDEAD_BEEF_0000_0000, 0, 0, 0, 0);
    @(negedge clk);
    check("wrap_inst", 64'(inst), 64'hDEAD_BEEF);
    check("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("wrap_next_valid", 64'(imem_req_valid), 1);
    check("wrap_next_addr", imem_req_addr, 64'h0);

    // Reset while a request is outstanding, then a stale response in IDLE.
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("mid_rst_req", 64'(imem_req_valid), 0);
    check("mid_rst_addr", imem_req_addr, 0);
    check("mid_rst_inst", 64'(inst), 0);
    check("mid_rst_inst_pc", inst_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, D, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_req", 64'(imem_req_valid), 1);
    check("post_rst_addr", imem_req_addr, 64'h8000_0000);
    check("post_rst_iv", 64'(inst_valid), 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 64'h0000_0000_0010_0073, 0, 0, 0, 0);
    @(negedge clk);
    check("ebreak_inst", 64'(inst), 64'h0010_0073);
    check("ebreak_iv", 64'(inst_valid), 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
`ifdef IFU_EBREAK_HALT_EN
    check("halt_halted", 64'(halted), 1);
    check("halt_iv", 64'(inst_valid), 0);
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 0, 0, 0, (k % 2) == 0, 64'h8000_1000);
      @(negedge clk);
      check($sformatf("halt%0d_req", k), 64'(imem_req_valid), 0);
      check($sformatf("halt%0d_halted", k), 64'(halted), 1);
    end
`else
    check("nohalt_halted", 64'(halted), 0);
    check("nohalt_req", 64'(imem_req_valid), 1);
    check("nohalt_addr", imem_req_addr, 64'h8000_0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
